// File: rtl/mont_exit.sv
// Bit-serial Montgomery exit reducer: out = in * 2^-DATA_WIDTH mod Q, valid/ready on both sides.
// Optional build macro MONT_EXIT_RADIX4_EN applies two radix-2 steps per RUN cycle.
module mont_exit #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned Q          = 3329,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);

`ifdef MONT_EXIT_RADIX4_EN
  localparam int unsigned ITER = (DATA_WIDTH + 1) / 2;
`else
  localparam int unsigned ITER = DATA_WIDTH;
`endif
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [DATA_WIDTH:0]   QW = (DATA_WIDTH + 1)'(Q);
  localparam logic [DATA_WIDTH-1:0] QD = DATA_WIDTH'(Q);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e                state;
  logic [DATA_WIDTH-1:0] t;
  logic [CNT_W-1:0]      cnt;
  logic [TAG_WIDTH-1:0]  tag_q;

  logic                  last_step;
  logic [DATA_WIDTH-1:0] step_val;
  logic [DATA_WIDTH-1:0] corr_val;
  logic                  accept;

  // One radix-2 step: halve T, adding Q first when T is odd so the shift is exact.
  function automatic logic [DATA_WIDTH-1:0] rstep(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, v} + (v[0] ? QW : '0);
    return sum[DATA_WIDTH:1];
  endfunction

  assign last_step = (cnt == LAST_CNT);

`ifdef MONT_EXIT_RADIX4_EN
  localparam bit ODD_WIDTH = (DATA_WIDTH % 2) == 1;
  logic [DATA_WIDTH-1:0] step_one;
  logic [DATA_WIDTH-1:0] step_two;

  always_comb begin
    step_one = rstep(t);
    step_two = rstep(step_one);
    // Odd widths leave a single step for the final cycle.
    step_val = (ODD_WIDTH && last_step) ? step_one : step_two;
  end
`else
  always_comb begin
    step_val = rstep(t);
  end
`endif

  // Pre-correction value never exceeds Q, so one subtract lands in 0..Q-1.
  always_comb begin
    corr_val = (step_val >= QD) ? (step_val - QD) : step_val;
  end

  always_comb begin
    in_ready = (state == StIdle) || ((state == StDone) && out_ready);
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      t         <= '0;
      cnt       <= '0;
      tag_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            t     <= in_data;
            tag_q <= in_tag;
            cnt   <= '0;
            state <= StRun;
          end
        end
        StRun: begin
          t   <= step_val;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            out_data  <= corr_val;
            out_tag   <= tag_q;
            out_valid <= 1'b1;
            state     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              t     <= in_data;
              tag_q <= in_tag;
              cnt   <= '0;
              state <= StRun;
            end else begin
              state <= StIdle;
            end
          end
        end
        default: begin
          state     <= StIdle;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exit.sv
// Directed-vector bench for mont_exit (Q=3329, DATA_WIDTH=12); honours MONT_EXIT_RADIX4_EN.
module tb_mont_exit;
  localparam int QM   = 3329;
  localparam int RINV = 2704;  // 4096^-1 mod 3329
  localparam int R2   = 2385;  // 4096^2 mod 3329
`ifdef MONT_EXIT_RADIX4_EN
  localparam int ITER = 6;
`else
  localparam int ITER = 12;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [3:0]  out_tag;

  int checks = 0;
  int errors = 0;

  mont_exit #(
    .DATA_WIDTH(12),
    .Q         (3329),
    .TAG_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  function automatic int gold(input int x);
    return int'((longint'(x) * RINV) % QM);
  endfunction

  function automatic int mo_mul(input int a, input int b);
    return int'(((longint'(a) * b) % QM) * RINV % QM);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Present one word from IDLE, wait for its result, then consume it.
  task automatic run_word(input int d, input int tg, output int res, output int rtag,
                          output int lat);
    int n;
    in_data  = 12'(d);
    in_tag   = 4'(tg);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res  = int'(out_data);
    rtag = int'(out_tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    int din;
    int tag;
    int exp;
  } vec_t;

  vec_t vecs[9];
  int   bb_words[6];

  initial begin
    int res, rtag, lat, d0, t0, stable, quiet;
    int k, got, cyc, last_cyc;
    logic hs, ob;
    int od, ot;

    vecs[0] = '{din: 767,  tag: 1,  exp: 1};
    vecs[1] = '{din: 506,  tag: 2,  exp: 5};
    vecs[2] = '{din: 0,    tag: 3,  exp: 0};
    vecs[3] = '{din: 3329, tag: 4,  exp: 0};
    vecs[4] = '{din: 4095, tag: 5,  exp: 626};
    vecs[5] = '{din: 1,    tag: 6,  exp: 2704};
    vecs[6] = '{din: 2,    tag: 7,  exp: 2079};
    vecs[7] = '{din: 3328, tag: 8,  exp: 625};
    vecs[8] = '{din: 1534, tag: 15, exp: 2};
    bb_words = '{767, 1534, 4095, 3329, 506, 1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    #12;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_tag", int'(out_tag), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_word(vecs[i].din, vecs[i].tag, res, rtag, lat);
      check($sformatf("vec%0d_data", i), res, vecs[i].exp);
      check($sformatf("vec%0d_tag", i), rtag, vecs[i].tag);
      check($sformatf("vec%0d_latency", i), lat, ITER);
    end

    // Full input sweep.
    for (int i = 0; i < 4096; i++) begin
      run_word(i, i % 16, res, rtag, lat);
      check($sformatf("sweep%0d_data", i), res, gold(i));
      check($sformatf("sweep%0d_tag", i), rtag, i % 16);
      if (res >= QM) check($sformatf("sweep%0d_range", i), res, QM - 1);
    end

    // Backpressure: word A stalls 20 cycles with word B pending.
    in_data = 12'd1534; in_tag = 4'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 12'd4095; in_tag = 4'd10;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_first_latency", lat, ITER);
    d0 = int'(out_data); t0 = int'(out_tag);
    check("bp_first_data", d0, 2);
    check("bp_first_tag", t0, 9);
    stable = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (int'(out_data) != d0 || int'(out_tag) != t0 || in_ready !== 1'b0 || out_valid !== 1'b1)
        stable = 0;
    end
    check("bp_stall_stable", stable, 1);
    out_ready = 1'b1;
    #1;
    check("bp_handover_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_after_take_valid", int'(out_valid), 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_second_latency", lat, ITER);
    check("bp_second_data", int'(out_data), 626);
    check("bp_second_tag", int'(out_tag), 10);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Back-to-back streaming with both handshakes held high.
    k = 0; got = 0; cyc = 0; last_cyc = 0;
    in_data = 12'(bb_words[0]); in_tag = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
    while (got < 6 && cyc < 300) begin
      hs = in_valid && in_ready;
      ob = out_valid && out_ready;
      od = int'(out_data); ot = int'(out_tag);
      @(posedge clk); #1; cyc++;
      if (ob) begin
        check($sformatf("b2b%0d_data", got), od, gold(bb_words[got]));
        check($sformatf("b2b%0d_tag", got), ot, got);
        if (got > 0) check($sformatf("b2b%0d_spacing", got), cyc - last_cyc, ITER + 1);
        last_cyc = cyc;
        got++;
      end
      if (hs) begin
        k++;
        if (k < 6) begin
          in_data = 12'(bb_words[k]); in_tag = 4'(k);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("b2b_count", got, 6);
    check("b2b_accepted", k, 6);
    out_ready = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of RUN.
    run_word(1534, 3, res, rtag, lat);
    check("pre_reset_data", res, 2);
    in_data = 12'd100; in_tag = 4'd12; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_out_tag", int'(out_tag), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    quiet = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) quiet = 0;
    end
    check("midrst_no_output", quiet, 1);
    run_word(767, 7, res, rtag, lat);
    check("postrst_data", res, 1);
    check("postrst_tag", rtag, 7);
    check("postrst_latency", lat, ITER);

    // Chain from the Montgomery multiplier: mo_mul(a, R^2) enters, a comes out.
    for (int a = 1; a <= 100; a++) begin
      run_word(mo_mul(a, R2), a % 16, res, rtag, lat);
      check($sformatf("chain%0d", a), res, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
